// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: bridge FSM states, AXI size/burst constants, lane steering and default AXI structs.
package apb2axi_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ax_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_64_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_64_t;
  function automatic logic [31:0] lane_sel(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction
  function automatic logic [7:0] strb_steer(input logic [3:0] s, input logic hi);
    return hi ? {s, 4'b0} : {4'b0, s};
  endfunction
endpackage

// File: rtl/apb2axi_32_64_if.sv
// apb2axi_32_64_if: APB4 and AXI4 signal bundle around the bridge; master is the requester/AXI-memory side.
interface apb2axi_32_64_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [31:0] pwdata;
  logic [3:0] pstrb;
  logic pready;
  logic [31:0] prdata;
  logic pslverr;
  apb2axi_pkg::axi_req_64_t axi_req;
  apb2axi_pkg::axi_resp_64_t axi_resp;
  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, axi_resp,
    input  pready, prdata, pslverr, axi_req
  );
  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, axi_resp,
    output pready, prdata, pslverr, axi_req
  );
endinterface

// File: rtl/apb2axi_32_64.sv
// apb2axi_32_64: APB4 slave to AXI4 master bridge, 32-bit APB onto a 64-bit AXI data path.
// One single-beat AXI transfer per APB access; misaligned accesses are rejected locally.
module apb2axi_32_64 #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter type axi_req_t = apb2axi_pkg::axi_req_64_t,
  parameter type axi_resp_t = apb2axi_pkg::axi_resp_64_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic psel_i,
  input  logic penable_i,
  input  logic pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0] pstrb_i,
  output logic pready_o,
  output logic [31:0] prdata_o,
  output logic pslverr_o,
  output axi_req_t axi_req_o,
  input  axi_resp_t axi_resp_i
);
  import apb2axi_pkg::*;
  state_e state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] strb_q, strb_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic [31:0] prdata_q, prdata_d;
  logic pslverr_q, pslverr_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused;
  assign aw_hs = axi_req_o.aw_valid & axi_resp_i.aw_ready;
  assign w_hs = axi_req_o.w_valid & axi_resp_i.w_ready;
  assign b_hs = axi_req_o.b_ready & axi_resp_i.b_valid;
  assign ar_hs = axi_req_o.ar_valid & axi_resp_i.ar_ready;
  assign r_hs = axi_req_o.r_ready & axi_resp_i.r_valid;
  assign unused = ^{axi_resp_i, write_q};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      paddr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      prdata_q <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      prdata_q <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    prdata_d = prdata_q;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: if (psel_i && !penable_i) begin
        paddr_d = paddr_i;
        write_d = pwrite_i;
        wdata_d = pwdata_i;
        strb_d = pstrb_i;
        pslverr_d = |paddr_i[1:0];
        state_d = |paddr_i[1:0] ? DONE : pwrite_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (b_hs) begin
        pslverr_d = axi_resp_i.b.resp[1];
        state_d = DONE;
      end
      RD_REQ: state_d = ar_hs ? RD_RESP : RD_REQ;
      RD_RESP: if (r_hs) begin
        pslverr_d = axi_resp_i.r.resp[1];
        prdata_d = lane_sel(axi_resp_i.r.data, paddr_q[2]);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // AW and AR carry identical attributes; only one of them is ever valid
  always_comb begin
    axi_req_o = '0;
    axi_req_o.aw.id = AXI_ID;
    axi_req_o.aw.addr = BASE_ADDR + AXI_ADDR_WIDTH'(paddr_q);
    axi_req_o.aw.size = AXI_SIZE_4B;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.ar = axi_req_o.aw;
    axi_req_o.w.data = {2{wdata_q}};
    axi_req_o.w.strb = strb_steer(strb_q, paddr_q[2]);
    axi_req_o.w.last = 1'b1;
    axi_req_o.aw_valid = state_q == WR_REQ && !aw_done_q;
    axi_req_o.w_valid = state_q == WR_REQ && !w_done_q;
    axi_req_o.b_ready = state_q == WR_RESP;
    axi_req_o.ar_valid = state_q == RD_REQ;
    axi_req_o.r_ready = state_q == RD_RESP;
  end
  // an abandoned APB access (psel gone) still drains through DONE, silently
  assign pready_o = state_q == DONE && psel_i;
  assign pslverr_o = pready_o && pslverr_q;
  assign prdata_o = prdata_q;
endmodule

// File: doc/apb2axi_32_64.md
APB2AXI_32_64 -- requirements
Module: apb2axi_32_64

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, AXI ID width.
REQ-003 SHALL have parameter AXI_ID, default 0, constant ID on AW/AR.
REQ-004 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0, added to the APB address to form the AXI address.
REQ-006 SHALL have parameter types axi_req_t and axi_resp_t: AXI4 master request/response structs, 64-bit data, 8-bit strobe.
REQ-007 SHALL provide clk_i, input, 1, the single clock.
REQ-008 SHALL provide rst_ni, input, 1, asynchronous active-low reset.
REQ-009 SHALL provide paddr_i, psel_i, penable_i, pwrite_i (inputs; APB_ADDR_WIDTH, 1, 1, 1 bits): APB4 slave control.
REQ-010 SHALL provide pwdata_i (input, 32), APB write data, and pstrb_i (input, 4), byte strobes.
REQ-011 SHALL provide pready_o (output, 1), prdata_o (output, 32) and pslverr_o (output, 1): APB completion.
REQ-012 SHALL provide axi_req_o (output, axi_req_t) and axi_resp_i (input, axi_resp_t): the AXI4 master port.

Function
REQ-013 SHALL be an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-014 In IDLE, on an edge with psel_i=1 and penable_i=0, SHALL latch addr, write, wdata and strb, then go to WR_REQ or RD_REQ.
REQ-015 If the latched paddr[1:0]!=0, SHALL go directly to DONE with pslverr_o=1 and issue no AXI transaction.
REQ-016 AXI address SHALL be BASE_ADDR + zero-extended paddr, truncated to AXI_ADDR_WIDTH (wrap, no carry out).
REQ-017 AXI attributes SHALL be: len=0, size=3'b010, burst=INCR, prot=0, cache=0, lock=0, qos=0, region=0, user=0, id=AXI_ID; w.last=1.
REQ-018 Writes: pwdata SHALL be placed in bits [63:32] when addr[2]=1, else [31:0], replicated to both halves; wstrb = pstrb<<4 if addr[2], else pstrb.
REQ-019 WR_REQ SHALL assert aw_valid and w_valid in the same first cycle and track each handshake with its own done flag; each valid SHALL drop after its own handshake.
REQ-020 When both the AW and W handshakes are done, including in the same cycle, SHALL go to WR_RESP with b_ready=1.
REQ-021 RD_REQ SHALL hold ar_valid until ar_ready, then go to RD_RESP with r_ready=1.
REQ-022 On the b or r handshake, SHALL register pslverr = resp[1] and prdata = the 32-bit half of r.data selected by addr[2], then enter DONE.
REQ-023 DONE SHALL assert pready_o for exactly one cycle, then return to IDLE.
REQ-024 Outside DONE, pready_o SHALL be 0; prdata_o SHALL hold its last value; pslverr_o SHALL be 0.
REQ-025 Latency SHALL be: AXI valid asserted in the cycle after SETUP; pready_o in the cycle after the final AXI handshake.
REQ-026 If psel_i drops mid-transfer, SHALL still complete the AXI transaction and return to IDLE without asserting pready_o.
REQ-027 AXI valids SHALL never be deasserted before their handshake (AXI stability rule).
REQ-028 SHALL have at most one outstanding AXI transaction.

Reset
REQ-029 rst_ni low SHALL asynchronously force IDLE, all AXI valids and readies 0, pready_o 0, pslverr_o 0, prdata_o 0, and all latches and done flags 0.
REQ-030 Reset mid-transaction SHALL abandon the transfer; no response is later forwarded to APB.

Structure
REQ-031 Package apb2axi_pkg SHALL hold the state enum, the AXI size/burst constants and a lane-steering function.
REQ-032 SHALL be a single module; no sub-module is needed.

Verification
REQ-033 Write paddr=0x104, pwdata=0xDEADBEEF, pstrb=0xF, BASE_ADDR=0x8000_0000 -> aw.addr=0x8000_0104, w.data[63:32]=0xDEADBEEF, wstrb=0xF0; b OKAY -> single pready_o, pslverr_o=0.
REQ-034 Read paddr=0x100, r.data=0x1111_2222_3333_4444 -> prdata_o=0x3333_4444; paddr=0x104 -> prdata_o=0x1111_2222.
REQ-035 aw_ready delayed 5 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid holds 5 cycles, then b_ready=1.
REQ-036 b.resp=SLVERR (2'b10) -> pslverr_o=1 together with pready_o; paddr=0x102 -> pslverr_o=1 and no aw/ar valid ever asserted.
REQ-037 rst_ni pulsed low while in RD_RESP -> all outputs 0 immediately, next APB read completes normally.
